// File: rtl/cim_sacc.sv
// cim_sacc: shift-and-add accumulator for bit-serial compute-in-memory MAC passes,
// MSB plane first, with optional negative weight on the MSB plane for signed activations.
module cim_sacc #(
    parameter int N_COL = 8,
    parameter int PS_W  = 4,
    parameter int ACC_W = 16,
    parameter int NBIT  = 12
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   signed_in,
    input  logic                   psum_vld,
    input  logic [N_COL*PS_W-1:0]  psum,
    output logic [5:0]             sel,
    output logic                   busy,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [N_COL*ACC_W-1:0] acc_out
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;
    logic sgn, accept, last, launch;
    assign launch = state == IDLE && start;
    assign accept = state == RUN && psum_vld;
    assign last   = sel == 6'(NBIT - 1);
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    always_comb
        state_nxt = state == IDLE ? (start ? RUN : IDLE) :
                    state == RUN  ? (accept && last ? DONE : RUN) :
                                    (out_rdy ? IDLE : DONE);
    always_comb begin
        busy    = state != IDLE;
        out_vld = state == DONE;
    end
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            sel <= '0;
            sgn <= 1'b0;
        end else if (launch) begin
            sel <= '0;
            sgn <= signed_in;
        end else if (accept && !last) begin
            sel <= sel + 6'd1;
        end
    for (genvar c = 0; c < N_COL; c++) begin : g_col
        logic [ACC_W-1:0] acc, ps, term;
        assign ps   = ACC_W'(psum[c*PS_W +: PS_W]);
        // signed activations: the MSB plane carries weight -2^(NBIT-1)
        assign term = (sel == '0 && sgn) ? -ps : ps;
        always_ff @(posedge clk or negedge rstn)
            if (!rstn)       acc <= '0;
            else if (launch) acc <= '0;
            else if (accept) acc <= {acc[ACC_W-2:0], 1'b0} + term;
        assign acc_out[c*ACC_W +: ACC_W] = acc;
    end
endmodule
